// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder family: width limits and a
// reference model of the exact (WIDTH+1)-bit sum.
package adder_pkg;

    localparam int unsigned ADDER_MAX_WIDTH = 64;

    // Reference result {carry, sum} for the low `width` bits of a and b plus cin.
    // The carry lands at bit position `width`. Higher bits of the result are zero.
    function automatic logic [ADDER_MAX_WIDTH:0] adder_ref(
        input logic [ADDER_MAX_WIDTH-1:0] a,
        input logic [ADDER_MAX_WIDTH-1:0] b,
        input logic                       cin,
        input int unsigned                width
    );
        logic [ADDER_MAX_WIDTH-1:0] mask;
        logic [ADDER_MAX_WIDTH:0]   total;
        if (width >= ADDER_MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        total = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
        return total;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell: sum is the three-input parity, carry is the
// majority of the three inputs written as generate | (carry & propagate).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic propagate;
    logic generate_bit;

    assign propagate    = a ^ b;
    assign generate_bit = a & b;
    assign s            = propagate ^ cin;
    assign cout         = generate_bit | (cin & propagate);

endmodule

// File: rtl/full_adder_dataflow.sv
// Registered ripple-carry adder. A chain of full_adder_cell instances forms the
// combinational sum; one register stage captures it when in_valid is high.
// Outputs hold their value between accepted inputs; out_valid pulses for one
// cycle per accepted input.
module full_adder_dataflow
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid
);

    // Widths outside 1..ADDER_MAX_WIDTH are not supported; this localparam makes
    // the intended bound visible next to the parameter it constrains.
    localparam int unsigned MAX_WIDTH = ADDER_MAX_WIDTH;

    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next;

    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             valid_reg;

    assign carry_chain[0] = carry_in;

    // Ripple chain: carry out of cell gi feeds carry in of cell gi+1.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry_chain[gi]),
                .s    (sum_next[gi]),
                .cout (carry_chain[gi+1])
            );
        end
    endgenerate

    assign carry_next = carry_chain[WIDTH];

    // Output register stage: reset wins over in_valid; idle cycles hold the
    // result so unknown inputs while in_valid=0 never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg   <= sum_next;
                carry_reg <= carry_next;
            end
        end
    end

    assign sum       = sum_reg;
    assign carry_out = carry_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_full_adder_dataflow.sv
// Directed and randomised checks of full_adder_dataflow at WIDTH=1, 8 and 16.
module tb_full_adder_dataflow;
    import adder_pkg::*;

    logic clk;
    logic rst;

    // WIDTH=1 instance
    logic [0:0]  a1, b1, s1;
    logic        c1, v1, co1, ov1;
    // WIDTH=8 instance
    logic [7:0]  a8, b8, s8;
    logic        c8, v8, co8, ov8;
    // WIDTH=16 instance
    logic [15:0] a16, b16, s16;
    logic        c16, v16, co16, ov16;

    int checks;
    int failures;

    full_adder_dataflow #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(c1), .in_valid(v1),
        .sum(s1), .carry_out(co1), .out_valid(ov1)
    );

    full_adder_dataflow #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .carry_in(c8), .in_valid(v8),
        .sum(s8), .carry_out(co8), .out_valid(ov8)
    );

    full_adder_dataflow #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .carry_in(c16), .in_valid(v16),
        .sum(s16), .carry_out(co16), .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic tt_sum  [8];
    logic tt_cout [8];
    logic [2:0] tt_vec;

    logic [15:0] exp_sum16;
    logic        exp_co16;
    logic        exp_ov16;
    logic [64:0] ref_val;

    initial begin
        checks   = 0;
        failures = 0;
        tt_sum   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tt_cout  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        a16 = '0; b16 = '0; c16 = 1'b0; v16 = 1'b0;

        // Reset with active-looking inputs: outputs must stay cleared.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            $display("reset cycle %0d: s1=%0h co1=%0b ov1=%0b s8=%0h", i, s1, co1, ov1, s8);
            check_eq("reset_sum1",  64'(s1),  64'h0);
            check_eq("reset_cout1", 64'(co1), 64'h0);
            check_eq("reset_ov1",   64'(ov1), 64'h0);
            check_eq("reset_sum8",  64'(s8),  64'h0);
            check_eq("reset_ov8",   64'(ov8), 64'h0);
        end
        rst = 1'b0;
        v8  = 1'b0;

        // WIDTH=1 truth table, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            tt_vec = 3'(i);
            a1 = tt_vec[2]; b1 = tt_vec[1]; c1 = tt_vec[0]; v1 = 1'b1;
            step();
            $display("tt a=%0b b=%0b cin=%0b -> sum=%0b cout=%0b ov=%0b", a1, b1, c1, s1, co1, ov1);
            check_eq("tt_sum",  64'(s1),  64'(tt_sum[i]));
            check_eq("tt_cout", 64'(co1), 64'(tt_cout[i]));
            check_eq("tt_ov",   64'(ov1), 64'h1);
        end

        // Hold: capture 1+0+0, then idle with junk on the inputs.
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        step();
        $display("hold load: sum=%0b cout=%0b ov=%0b", s1, co1, ov1);
        check_eq("hold_load_sum", 64'(s1),  64'h1);
        check_eq("hold_load_ov",  64'(ov1), 64'h1);
        v1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
            end else begin
                a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            end
            step();
            $display("hold idle %0d: sum=%0b cout=%0b ov=%0b", i, s1, co1, ov1);
            check_eq("hold_sum",  64'(s1),  64'h1);
            check_eq("hold_cout", 64'(co1), 64'h0);
            check_eq("hold_ov",   64'(ov1), 64'h0);
        end
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

        // WIDTH=8 wrap cases.
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
        step();
        $display("w8 FF+01+0: sum=%0h cout=%0b", s8, co8);
        check_eq("wrap1_sum",  64'(s8),  64'h00);
        check_eq("wrap1_cout", 64'(co8), 64'h1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        step();
        $display("w8 FF+FF+1: sum=%0h cout=%0b", s8, co8);
        check_eq("wrap2_sum",  64'(s8),  64'hFF);
        check_eq("wrap2_cout", 64'(co8), 64'h1);

        // Mid-stream reset on the second of three back-to-back vectors.
        a8 = 8'h03; b8 = 8'h04; c8 = 1'b0;
        step();
        $display("mid v1: sum=%0h cout=%0b ov=%0b", s8, co8, ov8);
        check_eq("mid1_sum", 64'(s8),  64'h07);
        check_eq("mid1_ov",  64'(ov8), 64'h1);
        a8 = 8'h20; b8 = 8'h30; c8 = 1'b1; rst = 1'b1;
        step();
        $display("mid v2 (reset): sum=%0h cout=%0b ov=%0b", s8, co8, ov8);
        check_eq("mid2_sum", 64'(s8),  64'h00);
        check_eq("mid2_ov",  64'(ov8), 64'h0);
        rst = 1'b0;
        a8 = 8'h0A; b8 = 8'h05; c8 = 1'b1;
        step();
        $display("mid v3: sum=%0h cout=%0b ov=%0b", s8, co8, ov8);
        check_eq("mid3_sum",  64'(s8),  64'h10);
        check_eq("mid3_cout", 64'(co8), 64'h0);
        check_eq("mid3_ov",   64'(ov8), 64'h1);
        v8 = 1'b0;
        v1 = 1'b0;

        // Random WIDTH=16 traffic against the package reference.
        exp_sum16 = s16;
        exp_co16  = co16;
        for (int i = 0; i < 10000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            v16 = 1'($urandom);
            exp_ov16 = v16;
            if (v16) begin
                ref_val   = adder_ref({48'd0, a16}, {48'd0, b16}, c16, 16);
                exp_sum16 = ref_val[15:0];
                exp_co16  = ref_val[16];
            end
            step();
            check_eq("rand_sum",  64'(s16),  64'(exp_sum16));
            check_eq("rand_cout", 64'(co16), 64'(exp_co16));
            check_eq("rand_ov",   64'(ov16), 64'(exp_ov16));
        end
        $display("random phase: 10000 cycles of WIDTH=16 traffic");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
